// File: rtl/decoder_scan_n_if.sv
// Bundles the select/control inputs and decoded outputs of decoder_scan_n.
// The slave modport is the decoder's view; master is the driver's view.
interface decoder_scan_n_if #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
);
  logic [SEL_W-1:0]      sel_in;
  logic                  en_in;
  logic                  start_in;
  logic                  stop_in;
  logic [DWELL_W-1:0]    dwell_in;
  logic [2**SEL_W-1:0]   y_out;
  logic [SEL_W-1:0]      idx_out;
  logic                  busy_out;
  logic                  wrap_out;

  modport slave (
    input  sel_in, en_in, start_in, stop_in, dwell_in,
    output y_out, idx_out, busy_out, wrap_out
  );

  modport master (
    output sel_in, en_in, start_in, stop_in, dwell_in,
    input  y_out, idx_out, busy_out, wrap_out
  );
endinterface

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with an auto-scan mode that steps the index with a programmable dwell.
// All outputs are registered: one cycle from inputs to y_out/idx_out; en_in low blanks and freezes the scan.
module decoder_scan_n #(
  parameter int SEL_W      = 2,
  parameter int ACTIVE_LOW = 0,
  parameter int DWELL_W    = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  decoder_scan_n_if.slave  bus
);
  localparam int N = 2**SEL_W;
  localparam logic [N-1:0] BLANK = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               r_state, w_state;
  logic [SEL_W-1:0]     r_idx, w_idx;
  logic [N-1:0]         r_y, w_y;
  logic                 r_busy, w_busy;
  logic                 r_wrap, w_wrap;
  logic [DWELL_W-1:0]   r_cnt, w_cnt;
  logic [DWELL_W-1:0]   r_dwell, w_dwell;

  function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] idx, input logic en);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    if (!en)
      return BLANK;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_y     <= BLANK;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_y     <= w_y;
      r_busy  <= w_busy;
      r_wrap  <= w_wrap;
      r_cnt   <= w_cnt;
      r_dwell <= w_dwell;
    end
  end

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_y     = r_y;
    w_busy  = r_busy;
    w_wrap  = 1'b0;
    w_cnt   = r_cnt;
    w_dwell = r_dwell;
    case (r_state)
      IDLE: begin
        w_idx  = bus.sel_in;
        w_y    = decode(bus.sel_in, bus.en_in);
        w_busy = 1'b0;
        // stop has priority over a simultaneous start
        if (bus.start_in && !bus.stop_in) begin
          w_state = SCAN;
          w_busy  = 1'b1;
          w_dwell = bus.dwell_in;
          w_cnt   = '0;
        end
      end
      SCAN: begin
        if (bus.stop_in) begin
          w_state = IDLE;
          w_busy  = 1'b0;
          w_cnt   = '0;
          w_idx   = bus.sel_in;
          w_y     = decode(bus.sel_in, bus.en_in);
        end else if (bus.en_in) begin
          if (r_cnt == r_dwell) begin
            w_cnt  = '0;
            w_idx  = r_idx + SEL_W'(1);
            w_wrap = (r_idx == {SEL_W{1'b1}});
          end else begin
            w_cnt = r_cnt + DWELL_W'(1);
          end
          w_y = decode(w_idx, 1'b1);
        end else begin
          // disabled: hold index and dwell position, blank the outputs
          w_y = BLANK;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign bus.y_out    = r_y;
  assign bus.idx_out  = r_idx;
  assign bus.busy_out = r_busy;
  assign bus.wrap_out = r_wrap;
endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n: default 2-bit active-high instance plus a 3-bit active-low instance.
module tb_decoder_scan_n;
  logic clk_in = 1'b0;
  logic rst_in;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_in = ~clk_in;

  decoder_scan_n_if #(.SEL_W(2), .DWELL_W(4)) if0 ();
  decoder_scan_n_if #(.SEL_W(3), .DWELL_W(4)) if1 ();

  decoder_scan_n #(.SEL_W(2), .ACTIVE_LOW(0), .DWELL_W(4)) u0 (
    .clk_in(clk_in), .rst_in(rst_in), .bus(if0)
  );
  decoder_scan_n #(.SEL_W(3), .ACTIVE_LOW(1), .DWELL_W(4)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .bus(if1)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    if0.sel_in = 2'd3; if0.en_in = 1'b1; if0.start_in = 1'b1; if0.stop_in = 1'b0; if0.dwell_in = 4'd2;
    if1.sel_in = 3'd5; if1.en_in = 1'b1; if1.start_in = 1'b0; if1.stop_in = 1'b0; if1.dwell_in = 4'd0;
    #1 rst_in = 1'b1;
    #1;
    n_checks++; if (if0.y_out !== 4'b0000) begin n_fail++; $display("FAIL reset_y got %b expected 0000", if0.y_out); end
    n_checks++; if (if0.idx_out !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d expected 0", if0.idx_out); end
    n_checks++; if (if0.busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", if0.busy_out); end
    n_checks++; if (if0.wrap_out !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b expected 0", if0.wrap_out); end
    n_checks++; if (if1.y_out !== 8'hFF) begin n_fail++; $display("FAIL reset_y_al got %b expected 11111111", if1.y_out); end
    tick();
    n_checks++; if (if0.y_out !== 4'b0000) begin n_fail++; $display("FAIL reset_hold_y got %b expected 0000", if0.y_out); end
    n_checks++; if (if0.busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_hold_busy got %b expected 0", if0.busy_out); end
    n_checks++; if (if0.idx_out !== 2'd0) begin n_fail++; $display("FAIL reset_hold_idx got %0d expected 0", if0.idx_out); end
    if0.start_in = 1'b0;
    rst_in = 1'b0;
  endtask

  task automatic test_direct();
    logic [3:0] exp_y [4];
    exp_y = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    if0.en_in = 1'b1;
    for (int s = 0; s < 4; s++) begin
      if0.sel_in = s[1:0];
      if (s > 0) begin
        n_checks++; if (if0.y_out !== exp_y[s-1]) begin n_fail++; $display("FAIL direct_latency s=%0d got %b expected %b", s, if0.y_out, exp_y[s-1]); end
      end
      tick();
      n_checks++; if (if0.y_out !== exp_y[s]) begin n_fail++; $display("FAIL direct_y s=%0d got %b expected %b", s, if0.y_out, exp_y[s]); end
      n_checks++; if (if0.idx_out !== s[1:0]) begin n_fail++; $display("FAIL direct_idx s=%0d got %0d expected %0d", s, if0.idx_out, s); end
      tick();
      n_checks++; if (if0.y_out !== exp_y[s]) begin n_fail++; $display("FAIL direct_hold s=%0d got %b expected %b", s, if0.y_out, exp_y[s]); end
    end
    n_checks++; if (if0.busy_out !== 1'b0) begin n_fail++; $display("FAIL direct_busy got %b expected 0", if0.busy_out); end
    if0.en_in = 1'b0;
    tick();
    n_checks++; if (if0.y_out !== 4'b0000) begin n_fail++; $display("FAIL direct_blank got %b expected 0000", if0.y_out); end
    n_checks++; if (if0.idx_out !== 2'd3) begin n_fail++; $display("FAIL direct_blank_idx got %0d expected 3", if0.idx_out); end
  endtask

  task automatic test_scan();
    int         exp_idx [10];
    logic [3:0] exp_y   [10];
    exp_idx = '{2, 2, 3, 3, 0, 0, 1, 1, 2, 2};
    exp_y   = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
    if0.en_in = 1'b1; if0.sel_in = 2'd2; if0.dwell_in = 4'd1; if0.start_in = 1'b1;
    tick();
    // inputs changed mid-scan must not disturb it
    if0.start_in = 1'b0; if0.sel_in = 2'd0; if0.dwell_in = 4'd5;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (if0.idx_out !== exp_idx[i][1:0]) begin n_fail++; $display("FAIL scan_idx i=%0d got %0d expected %0d", i, if0.idx_out, exp_idx[i]); end
      n_checks++; if (if0.y_out !== exp_y[i]) begin n_fail++; $display("FAIL scan_y i=%0d got %b expected %b", i, if0.y_out, exp_y[i]); end
      n_checks++; if (if0.wrap_out !== (i == 4)) begin n_fail++; $display("FAIL scan_wrap i=%0d got %b expected %b", i, if0.wrap_out, (i == 4)); end
      n_checks++; if (if0.busy_out !== 1'b1) begin n_fail++; $display("FAIL scan_busy i=%0d got %b expected 1", i, if0.busy_out); end
      if0.start_in = (i == 5);
      tick();
    end
    if0.start_in = 1'b0;
  endtask

  task automatic test_freeze_stop();
    // entering: idx 3, first dwell cycle
    tick();
    n_checks++; if (if0.idx_out !== 2'd3) begin n_fail++; $display("FAIL freeze_pre_idx got %0d expected 3", if0.idx_out); end
    if0.en_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (if0.y_out !== 4'b0000) begin n_fail++; $display("FAIL freeze_y i=%0d got %b expected 0000", i, if0.y_out); end
      n_checks++; if (if0.idx_out !== 2'd3) begin n_fail++; $display("FAIL freeze_idx i=%0d got %0d expected 3", i, if0.idx_out); end
      n_checks++; if (if0.busy_out !== 1'b1) begin n_fail++; $display("FAIL freeze_busy i=%0d got %b expected 1", i, if0.busy_out); end
    end
    if0.en_in = 1'b1;
    tick();
    n_checks++; if (if0.idx_out !== 2'd0) begin n_fail++; $display("FAIL resume_idx got %0d expected 0", if0.idx_out); end
    n_checks++; if (if0.y_out !== 4'b0001) begin n_fail++; $display("FAIL resume_y got %b expected 0001", if0.y_out); end
    n_checks++; if (if0.wrap_out !== 1'b1) begin n_fail++; $display("FAIL resume_wrap got %b expected 1", if0.wrap_out); end
    tick();
    n_checks++; if (if0.wrap_out !== 1'b0) begin n_fail++; $display("FAIL resume_wrap_clr got %b expected 0", if0.wrap_out); end
    if0.sel_in = 2'd1; if0.stop_in = 1'b1; if0.start_in = 1'b1;
    tick();
    if0.stop_in = 1'b0; if0.start_in = 1'b0;
    n_checks++; if (if0.busy_out !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %b expected 0", if0.busy_out); end
    n_checks++; if (if0.idx_out !== 2'd1) begin n_fail++; $display("FAIL stop_idx got %0d expected 1", if0.idx_out); end
    n_checks++; if (if0.y_out !== 4'b0010) begin n_fail++; $display("FAIL stop_y got %b expected 0010", if0.y_out); end
    if0.stop_in = 1'b1; if0.start_in = 1'b1; if0.sel_in = 2'd2;
    tick();
    if0.stop_in = 1'b0; if0.start_in = 1'b0;
    tick();
    n_checks++; if (if0.busy_out !== 1'b0) begin n_fail++; $display("FAIL idle_both_busy got %b expected 0", if0.busy_out); end
    n_checks++; if (if0.y_out !== 4'b0100) begin n_fail++; $display("FAIL idle_both_y got %b expected 0100", if0.y_out); end
  endtask

  task automatic test_dwell_zero();
    if0.en_in = 1'b1; if0.sel_in = 2'd3; if0.dwell_in = 4'd0; if0.start_in = 1'b1;
    tick();
    if0.start_in = 1'b0;
    n_checks++; if (if0.idx_out !== 2'd3) begin n_fail++; $display("FAIL dz_idx0 got %0d expected 3", if0.idx_out); end
    tick();
    n_checks++; if (if0.idx_out !== 2'd0) begin n_fail++; $display("FAIL dz_idx1 got %0d expected 0", if0.idx_out); end
    n_checks++; if (if0.wrap_out !== 1'b1) begin n_fail++; $display("FAIL dz_wrap got %b expected 1", if0.wrap_out); end
    tick();
    n_checks++; if (if0.idx_out !== 2'd1) begin n_fail++; $display("FAIL dz_idx2 got %0d expected 1", if0.idx_out); end
    tick();
    n_checks++; if (if0.y_out !== 4'b0100) begin n_fail++; $display("FAIL dz_y3 got %b expected 0100", if0.y_out); end
    if0.stop_in = 1'b1;
    tick();
    if0.stop_in = 1'b0;
    n_checks++; if (if0.busy_out !== 1'b0) begin n_fail++; $display("FAIL dz_stop_busy got %b expected 0", if0.busy_out); end
    n_checks++; if (if0.y_out !== 4'b1000) begin n_fail++; $display("FAIL dz_stop_y got %b expected 1000", if0.y_out); end
  endtask

  task automatic test_async_reset();
    if0.en_in = 1'b1; if0.sel_in = 2'd1; if0.dwell_in = 4'd2; if0.start_in = 1'b1;
    tick();
    if0.start_in = 1'b0;
    tick();
    tick();
    n_checks++; if (if0.busy_out !== 1'b1) begin n_fail++; $display("FAIL ar_pre_busy got %b expected 1", if0.busy_out); end
    #2 rst_in = 1'b1;
    #1;
    n_checks++; if (if0.y_out !== 4'b0000) begin n_fail++; $display("FAIL ar_y got %b expected 0000", if0.y_out); end
    n_checks++; if (if0.idx_out !== 2'd0) begin n_fail++; $display("FAIL ar_idx got %0d expected 0", if0.idx_out); end
    n_checks++; if (if0.busy_out !== 1'b0) begin n_fail++; $display("FAIL ar_busy got %b expected 0", if0.busy_out); end
    n_checks++; if (if1.y_out !== 8'hFF) begin n_fail++; $display("FAIL ar_y_al got %b expected 11111111", if1.y_out); end
    #1 rst_in = 1'b0;
    tick();
    n_checks++; if (if0.busy_out !== 1'b0) begin n_fail++; $display("FAIL ar_post_busy got %b expected 0", if0.busy_out); end
    n_checks++; if (if0.idx_out !== 2'd1) begin n_fail++; $display("FAIL ar_post_idx got %0d expected 1", if0.idx_out); end
    n_checks++; if (if0.y_out !== 4'b0010) begin n_fail++; $display("FAIL ar_post_y got %b expected 0010", if0.y_out); end
    tick();
    n_checks++; if (if0.idx_out !== 2'd1) begin n_fail++; $display("FAIL ar_idle_idx got %0d expected 1", if0.idx_out); end
  endtask

  task automatic test_active_low();
    if1.en_in = 1'b1; if1.sel_in = 3'd5;
    tick();
    n_checks++; if (if1.y_out !== 8'b11011111) begin n_fail++; $display("FAIL al_y got %b expected 11011111", if1.y_out); end
    n_checks++; if (if1.idx_out !== 3'd5) begin n_fail++; $display("FAIL al_idx got %0d expected 5", if1.idx_out); end
    if1.en_in = 1'b0;
    tick();
    n_checks++; if (if1.y_out !== 8'hFF) begin n_fail++; $display("FAIL al_blank got %b expected 11111111", if1.y_out); end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_freeze_stop();
    test_dwell_zero();
    test_async_reset();
    test_active_low();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
